// File: rtl/model_scalar_arccosh_function.sv
// Behavioural binary64 arccosh model: y = acosh(x) solved by Newton-Raphson on cosh(y) = x.
// One Newton step per clock; START/READY handshake shared with the other scalar function models.
module model_scalar_arccosh_function #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64,
    parameter int unsigned ITERATIONS   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 OVERFLOW_OUT
);

    localparam logic [63:0] QNAN_BITS = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] PINF_BITS = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] ABS_MASK  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [CONTROL_SIZE-1:0] LAST_STEP = CONTROL_SIZE'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ITERATE,
        ENDER
    } state_t;

    state_t                  state;
    real                     x;
    real                     y;
    real                     step_c;
    logic [CONTROL_SIZE-1:0] counter;
    logic [63:0]             result;
    logic                    flag;
    logic [63:0]             x_bits_c;
    logic                    x_nan_c;
    logic                    x_pinf_c;

    // Operand classification and the Newton correction for the current iterate
    always_comb begin
        x_bits_c = $realtobits(x);
        x_nan_c  = (x_bits_c & ABS_MASK) > PINF_BITS;
        x_pinf_c = (x_bits_c == PINF_BITS);
        step_c   = ($cosh(y) - x) / $sinh(y);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            x            <= 0.0;
            y            <= 0.0;
            counter      <= '0;
            result       <= '0;
            flag         <= 1'b0;
            READY        <= 1'b0;
            DATA_OUT     <= '0;
            OVERFLOW_OUT <= 1'b0;
        end else begin
            READY <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        x     <= $bitstoreal(DATA_IN);
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (x_nan_c || x < 1.0) begin
                        result <= QNAN_BITS;
                        flag   <= 1'b1;
                        state  <= ENDER;
                    end else if (x_pinf_c) begin
                        result <= PINF_BITS;
                        flag   <= 1'b1;
                        state  <= ENDER;
                    end else if (x == 1.0) begin
                        result <= '0;
                        flag   <= 1'b0;
                        state  <= ENDER;
                    end else begin
                        // ln(2x) sits above the root, so iterates descend monotonically
                        y       <= $ln(2.0 * x);
                        counter <= '0;
                        flag    <= 1'b0;
                        state   <= ITERATE;
                    end
                end
                ITERATE: begin
                    y       <= y - step_c;
                    result  <= $realtobits(y - step_c);
                    counter <= counter + CONTROL_SIZE'(1);
                    if (step_c == 0.0 || counter == LAST_STEP) begin
                        state <= ENDER;
                    end
                end
                ENDER: begin
                    DATA_OUT     <= DATA_SIZE'(result);
                    OVERFLOW_OUT <= flag;
                    READY        <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_model_scalar_arccosh_function.sv
// Directed and randomized bench for model_scalar_arccosh_function against a closed-form acosh reference.
module tb_model_scalar_arccosh_function;

    localparam int unsigned ITER = 16;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ready;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    model_scalar_arccosh_function #(
        .DATA_SIZE(64),
        .CONTROL_SIZE(64),
        .ITERATIONS(ITER)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .START(start),
        .READY(ready),
        .DATA_IN(data_in),
        .DATA_OUT(data_out),
        .OVERFLOW_OUT(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed form written to stay finite for very large x
    function automatic real acosh_ref(input real v);
        return $ln(v) + $ln(1.0 + $sqrt(1.0 - 1.0 / (v * v)));
    endfunction

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_real(input string tag, input real obs, input real exp, input real tol);
        real err;
        real mag;
        logic ok;
        err = obs - exp;
        if (err < 0.0) err = -err;
        mag = (exp < 0.0) ? -exp : exp;
        ok = (err <= tol * mag);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%g expected=%g", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] din);
        @(negedge clk);
        start   = 1'b1;
        data_in = din;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat = number of edges after the START edge at which READY was first seen
    task automatic wait_ready(input int budget, output int lat, output logic got);
        lat = 0;
        got = 1'b0;
        while (lat < budget && !got) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready) got = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] din, output int lat);
        logic got;
        start_op(din);
        wait_ready(ITER + 3, lat, got);
        chk64({tag, "_ready_seen"}, 64'(got), 64'd1);
        @(posedge clk);
        #1;
        chk64({tag, "_ready_1cyc"}, 64'(ready), 64'd0);
    endtask

    task automatic count_ready(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ready) n++;
        end
    endtask

    initial begin
        int   lat;
        int   n;
        real  xr;
        real  scale;
        logic [63:0] held;

        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk64("rst_data_out", data_out, 64'd0);
        chk64("rst_overflow", 64'(overflow), 64'd0);
        chk64("rst_ready", 64'(ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // x == 1.0 exits from CHECK
        run_op("one", ONE, lat);
        chk64("one_latency", 64'(lat), 64'd2);
        chk64("one_data", data_out, 64'd0);
        chk64("one_flag", 64'(overflow), 64'd0);

        run_op("ten", $realtobits(10.0), lat);
        chk_real("ten_value", $bitstoreal(data_out), 2.993222846126381, 1e-12);
        chk_real("ten_ref", $bitstoreal(data_out), acosh_ref(10.0), 1e-12);
        chk64("ten_flag", 64'(overflow), 64'd0);
        checks++;
        assert (lat <= int'(ITER) + 3) else begin
            errors++;
            $error("FAIL ten_latency observed=%0d expected<=%0d", lat, ITER + 3);
        end

        run_op("cosh1", $realtobits(1.5430806348152437), lat);
        chk_real("cosh1_value", $bitstoreal(data_out), 1.0, 1e-12);
        chk_real("cosh1_inverse", $cosh($bitstoreal(data_out)), 1.5430806348152437, 1e-12);
        chk64("cosh1_flag", 64'(overflow), 64'd0);

        run_op("half", $realtobits(0.5), lat);
        chk64("half_latency", 64'(lat), 64'd2);
        chk64("half_data", data_out, QNAN);
        chk64("half_flag", 64'(overflow), 64'd1);

        run_op("pinf", PINF, lat);
        chk64("pinf_latency", 64'(lat), 64'd2);
        chk64("pinf_data", data_out, PINF);
        chk64("pinf_flag", 64'(overflow), 64'd1);

        run_op("nan_in", 64'h7FF0_0000_0000_0001, lat);
        chk64("nan_in_data", data_out, QNAN);
        chk64("nan_in_flag", 64'(overflow), 64'd1);

        run_op("big", $realtobits(1e300), lat);
        chk_real("big_value", $bitstoreal(data_out), acosh_ref(1e300), 1e-12);
        chk64("big_flag", 64'(overflow), 64'd0);

        // Outputs hold between operations
        held = data_out;
        repeat (5) @(posedge clk);
        #1;
        chk64("hold_data", data_out, held);

        // START and DATA_IN changes while busy are ignored
        start_op($realtobits(10.0));
        @(posedge clk);
        #1;
        start = 1'b1;
        data_in = $realtobits(2.0);
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            logic got;
            wait_ready(ITER + 3, lat, got);
            chk64("busy_ready_seen", 64'(got), 64'd1);
        end
        chk_real("busy_value", $bitstoreal(data_out), acosh_ref(10.0), 1e-12);
        count_ready(3 * ITER, n);
        chk64("busy_no_second", 64'(n), 64'd0);

        // Back-to-back with START held: pulses after edges 2, 5 and 8
        @(negedge clk);
        start = 1'b1;
        data_in = ONE;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            if (ready) n++;
            if (i == 8) start = 1'b0;
        end
        chk64("b2b_pulses", 64'(n), 64'd3);

        // Randomized legal operands
        for (int k = 0; k < 24; k++) begin
            scale = 1.5;
            for (int e = 0; e < int'($urandom_range(0, 60)); e++) scale = scale * 2.0;
            xr = scale * (1.0 + real'($urandom) / 4294967296.0);
            run_op("rand", $realtobits(xr), lat);
            chk_real("rand_value", $bitstoreal(data_out), acosh_ref(xr), 1e-12);
            chk64("rand_flag", 64'(overflow), 64'd0);
        end

        // Randomized domain errors: negative values and [0,1)
        for (int k = 0; k < 8; k++) begin
            xr = real'($urandom) / 4294967296.0;
            if (k % 2 == 1) xr = -100.0 * xr - 1.0;
            run_op("rdom", $realtobits(xr), lat);
            chk64("rdom_latency", 64'(lat), 64'd2);
            chk64("rdom_data", data_out, QNAN);
            chk64("rdom_flag", 64'(overflow), 64'd1);
        end

        // Asynchronous reset mid-ITERATE: outputs clear without a clock edge
        run_op("pre_abort", PINF, lat);
        start_op($realtobits(10.0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk64("abort_data", data_out, 64'd0);
        chk64("abort_flag", 64'(overflow), 64'd0);
        chk64("abort_ready", 64'(ready), 64'd0);
        count_ready(2, n);
        @(negedge clk);
        rst = 1'b0;
        begin
            int n2;
            count_ready(3 * ITER, n2);
            chk64("abort_no_ready", 64'(n + n2), 64'd0);
        end
        run_op("after_abort", $realtobits(10.0), lat);
        chk_real("after_abort_value", $bitstoreal(data_out), 2.993222846126381, 1e-12);
        chk64("after_abort_flag", 64'(overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
